// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs one imem request at a time and
// presents {PC, PC+4, instruction, valid} to IF/ID, squashing stale fetches on redirect.
//
// state | meaning
// REQ   | request for PC is on the bus, waiting for grant
// WAIT  | request granted, waiting for the response
// VALID | buffered instruction presented to IF/ID
// DROP  | redirect overtook a granted request, discard its response
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_F,
   output logic [31:0] PCPlus4_F,
   output logic [31:0] Instr_F,
   output logic        Valid_F
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;

   // Redirect targets are word aligned; the low bits are deliberately dropped.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^PCTargetE[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         buf_q   <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      if (PCSrcE) begin
         pc_d = {PCTargetE[31:2], 2'b00};
         unique case (state_q)
            S_REQ:   state_d = imem_gnt ? S_DROP : S_REQ;
            S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
            S_VALID: begin
               state_d = S_REQ;
               buf_d   = NOP_INSTR;
            end
            S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  buf_d   = imem_rdata;
                  state_d = S_VALID;
               end
            end
            S_VALID: begin
               if (!StallF) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   assign imem_req  = (state_q == S_REQ) && !rst;
   assign imem_addr = pc_q;
   assign PC_F      = pc_q;
   assign PCPlus4_F = pc_q + 32'd4;
   assign Valid_F   = (state_q == S_VALID);
   assign Instr_F   = (state_q == S_VALID) ? buf_q : NOP_INSTR;

endmodule
